// File: rtl/adc_stream_pkg.sv
// Shared frame layout for the ADC stream packer: metadata field offsets,
// the flags-word layout and the metadata packing helper.
package adc_stream_pkg;

    localparam int META_W    = 256;
    localparam int CNT_LSB   = 192;
    localparam int TS_LSB    = 128;
    localparam int FLAGS_LSB = 96;
    localparam int SEQ_LSB   = 64;
    localparam int OVF_LSB   = 48;
    localparam int NAVG_LSB  = 44;

    typedef struct packed {
        logic [1:0]  rsvd_hi;
        logic        marker;
        logic        inject;
        logic [3:0]  rsvd_lo;
        logic [7:0]  in_sync;
        logic [15:0] out_flags;
    } flags_word_t;

    function automatic logic [META_W-1:0] pack_meta(
        input logic [63:0]  cnt,
        input logic [63:0]  inject_ts,
        input flags_word_t  fw,
        input logic [31:0]  seq,
        input logic [15:0]  ovf,
        input logic [3:0]   navg
    );
        logic [META_W-1:0] m;
        m = '0;
        m[CNT_LSB   +: 64] = cnt;
        m[TS_LSB    +: 64] = inject_ts;
        m[FLAGS_LSB +: 32] = fw;
        m[SEQ_LSB   +: 32] = seq;
        m[OVF_LSB   +: 16] = ovf;
        m[NAVG_LSB  +: 4]  = navg;
        return m;
    endfunction

endpackage

// File: rtl/stream_fifo.sv
// First-word-fall-through frame FIFO with a registered output stage; the level
// counts both stored words and the word presented at the output.
module stream_fifo #(
    parameter  int WIDTH = 512,
    parameter  int DEPTH = 8,
    localparam int AW    = $clog2(DEPTH),
    localparam int LW    = AW + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_push_ok,
    output logic [WIDTH-1:0] o_data,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [LW-1:0]    o_level
);
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_out_data;
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [LW-1:0]    r_mem_cnt;
    logic             r_out_vld;
    logic             w_pop;
    logic             w_load;
    logic             w_wr;

    assign w_pop     = r_out_vld & i_ready;
    assign w_load    = (r_mem_cnt != '0) & (~r_out_vld | w_pop);
    assign o_level   = r_mem_cnt + LW'(r_out_vld);
    // A full FIFO still takes a word when the output is being popped this cycle.
    assign w_wr      = i_push & ((o_level < LW'(DEPTH)) | w_pop);
    assign o_push_ok = w_wr;
    assign o_valid   = r_out_vld;
    assign o_data    = r_out_vld ? r_out_data : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_mem_cnt <= '0;
            r_out_vld <= 1'b0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_load) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_mem_cnt <= r_mem_cnt + LW'(w_wr) - LW'(w_load);
            if (w_load) begin
                r_out_vld <= 1'b1;
            end else if (w_pop) begin
                r_out_vld <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= i_data;
        end
        if (w_load) begin
            r_out_data <= r_mem[r_rd_ptr];
        end
    end

endmodule

// File: rtl/adc_stream_packer.sv
// Multi-channel ADC averaging packer: sums 2**navg rounds of interleaved samples,
// packs sums and metadata into one bus word and streams frames out of a FIFO.
module adc_stream_packer
    import adc_stream_pkg::*;
#(
    parameter  int CHANNELS      = 4,
    parameter  int SAMPLE_WIDTH  = 12,
    parameter  int MAX_NAVG_LOG2 = 12,
    parameter  int FIFO_DEPTH    = 8,
    parameter  int BUSWIDTH      = 512,
    localparam int LVL_W         = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic [3:0]              navg_log2,
    input  logic                    sample_valid,
    input  logic [2:0]              sample_channel,
    input  logic [SAMPLE_WIDTH-1:0] sample_data,
    input  logic [7:0]              in_flags,
    input  logic [15:0]             out_flags,
    output logic [BUSWIDTH-1:0]     src_data,
    output logic                    src_valid,
    input  logic                    src_ready,
    output logic                    src_sop,
    output logic                    src_eop,
    output logic [15:0]             overflow_count,
    output logic [15:0]             order_err_count,
    output logic [LVL_W-1:0]        fifo_level
);
    localparam int RND_W = MAX_NAVG_LOG2 + 1;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    function automatic logic [3:0] clamp_navg(input logic [3:0] n);
        return (int'(n) > MAX_NAVG_LOG2) ? 4'(MAX_NAVG_LOG2) : n;
    endfunction

    logic [63:0]              r_cnt;
    logic [7:0]               r_flags_s1;
    logic [7:0]               r_flags_s2;
    logic [1:0]               r_flags_s3;
    logic                     r_inject_latch;
    logic                     r_marker_latch;
    logic [63:0]              r_inject_ts;
    logic [31:0]              r_acc [CHANNELS];
    logic [2:0]               r_exp_ch;
    logic [MAX_NAVG_LOG2-1:0] r_round;
    logic [3:0]               r_navg;
    logic [31:0]              r_seq;
    logic [15:0]              r_ovf;
    logic [15:0]              r_oerr;

    logic                     w_inj_fall;
    logic                     w_mrk_fall;
    logic                     w_accept;
    logic                     w_match;
    logic                     w_mismatch;
    logic                     w_first;
    logic                     w_ch_last;
    logic                     w_close;
    logic                     w_hold_clear;
    logic [3:0]               w_navg_eff;
    logic [RND_W-1:0]         w_round_last;
    logic [31:0]              w_sum [CHANNELS];
    flags_word_t              w_fw;
    logic [BUSWIDTH-1:0]      w_frame;
    logic                     w_push_ok;

    logic                     r_vld_p1;
    logic [31:0]              r_sums_p1 [CHANNELS];
    logic [63:0]              r_cnt_p1;
    logic [31:0]              r_seq_p1;
    logic [3:0]               r_navg_p1;

    assign w_inj_fall   = r_flags_s3[0] & ~r_flags_s2[0];
    assign w_mrk_fall   = r_flags_s3[1] & ~r_flags_s2[1];
    assign w_accept     = enable & sample_valid;
    assign w_match      = w_accept & (sample_channel == r_exp_ch);
    assign w_mismatch   = w_accept & ~w_match;
    assign w_first      = (r_round == '0) & (r_exp_ch == '0);
    // Averaging depth is frozen by the first sample of a frame.
    assign w_navg_eff   = w_first ? clamp_navg(navg_log2) : r_navg;
    assign w_round_last = (RND_W'(1) << w_navg_eff) - RND_W'(1);
    assign w_ch_last    = (r_exp_ch == 3'(CHANNELS - 1));
    assign w_close      = w_match & w_ch_last & ({1'b0, r_round} == w_round_last);
    assign w_hold_clear = ~enable | w_mismatch | w_close;

    always_comb begin
        for (int c = 0; c < CHANNELS; c++) begin
            w_sum[c] = r_acc[c] +
                       ((w_match && (r_exp_ch == 3'(c))) ? 32'(sample_data) : 32'd0);
        end
    end

    // p0: synchroniser, flag latches, accumulation and frame close
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt          <= '0;
            r_flags_s1     <= '0;
            r_flags_s2     <= '0;
            r_flags_s3     <= '0;
            r_inject_latch <= 1'b0;
            r_marker_latch <= 1'b0;
            r_inject_ts    <= '0;
            r_exp_ch       <= '0;
            r_round        <= '0;
            r_navg         <= '0;
            r_seq          <= '0;
            r_ovf          <= '0;
            r_oerr         <= '0;
            r_vld_p1       <= 1'b0;
            for (int c = 0; c < CHANNELS; c++) begin
                r_acc[c] <= '0;
            end
        end else begin
            r_cnt      <= r_cnt + 64'd1;
            r_flags_s1 <= in_flags;
            r_flags_s2 <= r_flags_s1;
            r_flags_s3 <= r_flags_s2[1:0];
            if (w_inj_fall) begin
                r_inject_latch <= 1'b1;
                r_inject_ts    <= r_cnt;
            end else if (r_vld_p1) begin
                r_inject_latch <= 1'b0;
            end
            if (w_mrk_fall) begin
                r_marker_latch <= 1'b1;
            end else if (r_vld_p1) begin
                r_marker_latch <= 1'b0;
            end
            if (w_hold_clear) begin
                r_exp_ch <= '0;
                r_round  <= '0;
                for (int c = 0; c < CHANNELS; c++) begin
                    r_acc[c] <= '0;
                end
            end else if (w_match) begin
                for (int c = 0; c < CHANNELS; c++) begin
                    r_acc[c] <= w_sum[c];
                end
                if (w_ch_last) begin
                    r_exp_ch <= '0;
                    r_round  <= r_round + MAX_NAVG_LOG2'(1);
                end else begin
                    r_exp_ch <= r_exp_ch + 3'd1;
                end
            end
            if (w_match && w_first) begin
                r_navg <= w_navg_eff;
            end
            if (w_mismatch) begin
                r_oerr <= sat_inc16(r_oerr);
            end
            if (w_close) begin
                r_seq <= r_seq + 32'd1;
            end
            r_vld_p1 <= w_close;
            if (r_vld_p1 && !w_push_ok) begin
                r_ovf <= sat_inc16(r_ovf);
            end
        end
    end

    // p1: closed frame held for its push cycle
    always_ff @(posedge clk) begin
        if (w_close) begin
            for (int c = 0; c < CHANNELS; c++) begin
                r_sums_p1[c] <= w_sum[c];
            end
            r_cnt_p1  <= r_cnt;
            r_seq_p1  <= r_seq;
            r_navg_p1 <= w_navg_eff;
        end
    end

    // Flags and loss count are sampled at push so an edge in the close cycle still lands in this frame.
    always_comb begin
        w_fw           = '0;
        w_fw.marker    = r_marker_latch;
        w_fw.inject    = r_inject_latch;
        w_fw.in_sync   = r_flags_s2;
        w_fw.out_flags = out_flags;
        w_frame        = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            w_frame[BUSWIDTH-1-32*c -: 32] = r_sums_p1[c];
        end
        w_frame[META_W-1:0] = pack_meta(r_cnt_p1, r_inject_ts, w_fw, r_seq_p1, r_ovf, r_navg_p1);
    end

    stream_fifo #(
        .WIDTH (BUSWIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .i_push    (r_vld_p1),
        .i_data    (w_frame),
        .o_push_ok (w_push_ok),
        .o_data    (src_data),
        .o_valid   (src_valid),
        .i_ready   (src_ready),
        .o_level   (fifo_level)
    );

    assign src_sop         = src_valid;
    assign src_eop         = src_valid;
    assign overflow_count  = r_ovf;
    assign order_err_count = r_oerr;

endmodule

// File: tb/tb_adc_stream_packer.sv
// Directed bench for adc_stream_packer: a frame-level model predicts every
// delivered frame, plus hand-computed literal checks for the key scenarios.
module tb_adc_stream_packer;
    localparam int CH = 4;
    localparam int SW = 12;
    localparam int BW = 512;
    localparam int FD = 8;
    localparam int LW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          enable;
    logic [3:0]    navg_log2;
    logic          sample_valid;
    logic [2:0]    sample_channel;
    logic [SW-1:0] sample_data;
    logic [7:0]    in_flags;
    logic [15:0]   out_flags;
    logic [BW-1:0] src_data;
    logic          src_valid;
    logic          src_ready;
    logic          src_sop;
    logic          src_eop;
    logic [15:0]   overflow_count;
    logic [15:0]   order_err_count;
    logic [LW-1:0] fifo_level;

    always #5 clk = ~clk;

    adc_stream_packer #(
        .CHANNELS(CH), .SAMPLE_WIDTH(SW), .MAX_NAVG_LOG2(12), .FIFO_DEPTH(FD), .BUSWIDTH(BW)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .navg_log2(navg_log2),
        .sample_valid(sample_valid), .sample_channel(sample_channel), .sample_data(sample_data),
        .in_flags(in_flags), .out_flags(out_flags), .src_data(src_data), .src_valid(src_valid),
        .src_ready(src_ready), .src_sop(src_sop), .src_eop(src_eop),
        .overflow_count(overflow_count), .order_err_count(order_err_count), .fifo_level(fifo_level)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // ---------------- frame-level model ----------------
    typedef struct packed {
        logic [CH*32-1:0] sums;
        logic [63:0]      cnt;
        logic [31:0]      seq;
        logic [15:0]      ovf;
        logic [3:0]       navg;
    } frame_t;

    frame_t          exp_q[$];
    longint unsigned tb_cnt;
    logic [31:0]     m_acc [CH];
    int              m_exp_ch, m_round, m_navg, m_seq, m_ovf, m_oerr;
    logic [BW-1:0]   last_data;
    int              n_frames = 0;

    always @(posedge clk) tb_cnt <= reset ? 64'd0 : tb_cnt + 64'd1;

    task automatic model_clear_acc();
        for (int c = 0; c < CH; c++) m_acc[c] = 32'd0;
        m_exp_ch = 0;
        m_round  = 0;
    endtask

    task automatic model_clear();
        exp_q.delete();
        model_clear_acc();
        m_navg = 0;
        m_seq  = 0;
        m_ovf  = 0;
        m_oerr = 0;
    endtask

    task automatic close_frame();
        frame_t f;
        for (int c = 0; c < CH; c++) f.sums[(CH-1-c)*32 +: 32] = m_acc[c];
        f.cnt  = tb_cnt;
        f.seq  = 32'(m_seq);
        f.ovf  = 16'(m_ovf);
        f.navg = 4'(m_navg);
        m_seq++;
        if (exp_q.size() < FD) exp_q.push_back(f);
        else if (m_ovf < 65535) m_ovf++;
        model_clear_acc();
    endtask

    task automatic model_accept(input int ch, input int data);
        if (ch != m_exp_ch) begin
            model_clear_acc();
            if (m_oerr < 65535) m_oerr++;
        end else begin
            if (m_exp_ch == 0 && m_round == 0)
                m_navg = (int'(navg_log2) > 12) ? 12 : int'(navg_log2);
            m_acc[ch] = m_acc[ch] + 32'(data);
            if (ch == CH - 1) begin
                m_exp_ch = 0;
                m_round++;
                if (m_round == (1 << m_navg)) close_frame();
            end else begin
                m_exp_ch++;
            end
        end
    endtask

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        frame_t f;
        if (!reset && src_valid && src_ready) begin
            check("sop_eq_valid", 64'(src_sop), 64'd1);
            check("eop_eq_valid", 64'(src_eop), 64'd1);
            if (exp_q.size() == 0) begin
                check("unexpected_frame", 64'd1, 64'd0);
            end else begin
                f = exp_q.pop_front();
                check("frame_sums", 64'(src_data[BW-1 -: CH*32] == f.sums), 64'd1);
                check("frame_cnt", src_data[255:192], f.cnt);
                check("frame_seq", 64'(src_data[95:64]), 64'(f.seq));
                check("frame_ovf", 64'(src_data[63:48]), 64'(f.ovf));
                check("frame_navg", 64'(src_data[47:44]), 64'(f.navg));
                check("frame_outflags", 64'(src_data[111:96]), 64'(out_flags));
            end
            last_data = src_data;
            n_frames++;
        end
    end

    // ---------------- driver helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int ch, input int data);
        sample_valid   = 1'b1;
        sample_channel = 3'(ch);
        sample_data    = SW'(data);
        if (enable) model_accept(ch, data);
        tick();
        sample_valid   = 1'b0;
    endtask

    task automatic send_round(input int base);
        for (int c = 0; c < CH; c++) send(c, base + c);
    endtask

    task automatic drain(input string name);
        int k = 0;
        while (exp_q.size() != 0 && k < 300) begin
            tick();
            k++;
        end
        check(name, 64'(k < 300), 64'd1);
    endtask

    task automatic pulse_reset();
        reset        = 1'b1;
        sample_valid = 1'b0;
        model_clear();
        tick();
        check("rst_src_valid", 64'(src_valid), 64'd0);
        check("rst_fifo_level", 64'(fifo_level), 64'd0);
        reset = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        longint unsigned t_inj;
        int base_frames;
        reset = 1'b1; enable = 1'b0; navg_log2 = 4'd0; sample_valid = 1'b0;
        sample_channel = 3'd0; sample_data = '0; in_flags = 8'h00;
        out_flags = 16'hA5C3; src_ready = 1'b1;
        model_clear();
        repeat (3) tick();
        check("rst_valid", 64'(src_valid), 64'd0);
        check("rst_data", 64'(src_data == '0), 64'd1);
        check("rst_level", 64'(fifo_level), 64'd0);
        check("rst_ovf", 64'(overflow_count), 64'd0);
        check("rst_oerr", 64'(order_err_count), 64'd0);
        reset = 1'b0;
        enable = 1'b1;
        tick();

        // 4 rounds of constant channel values, latency 3 clk from last sample
        navg_log2 = 4'd2;
        for (int r = 0; r < 4; r++) begin
            send(0, 12'h001); send(1, 12'h010); send(2, 12'h100);
            if (r < 3) send(3, 12'hFFF);
        end
        send(3, 12'hFFF);
        tick();
        check("lat_not_yet", 64'(src_valid), 64'd0);
        tick();
        check("lat_3clk", 64'(src_valid), 64'd1);
        drain("t1_drain");
        check("t1_acc0", 64'(last_data[511:480]), 64'h4);
        check("t1_acc1", 64'(last_data[479:448]), 64'h40);
        check("t1_acc2", 64'(last_data[447:416]), 64'h400);
        check("t1_acc3", 64'(last_data[415:384]), 64'h3FFC);
        check("t1_seq", 64'(last_data[95:64]), 64'd0);
        check("t1_navg", 64'(last_data[47:44]), 64'd2);

        // overflow: 10 frames into an 8-deep FIFO with the sink stalled
        pulse_reset();
        src_ready = 1'b0;
        navg_log2 = 4'd0;
        for (int f = 0; f < 10; f++) send_round(f * 16);
        repeat (3) tick();
        check("t2_level", 64'(fifo_level), 64'd8);
        check("t2_ovf", 64'(overflow_count), 64'd2);
        base_frames = n_frames;
        src_ready = 1'b1;
        drain("t2_drain");
        check("t2_delivered", 64'(n_frames - base_frames), 64'd8);
        check("t2_last_seq", 64'(last_data[95:64]), 64'd7);
        send_round(12'h200);
        drain("t2_next_drain");
        check("t2_next_seq", 64'(last_data[95:64]), 64'd10);
        check("t2_next_ovf", 64'(last_data[63:48]), 64'd2);

        // channel order error then a clean round
        pulse_reset();
        send(0, 1); send(1, 2); send(3, 3);
        tick();
        check("t3_oerr", 64'(order_err_count), 64'd1);
        send(0, 12'h11); send(1, 12'h22); send(2, 12'h33); send(3, 12'h44);
        drain("t3_drain");
        check("t3_acc0", 64'(last_data[511:480]), 64'h11);
        check("t3_acc3", 64'(last_data[415:384]), 64'h44);

        // inject falling edge and timestamp, then marker on the following frame
        in_flags = 8'h01;
        repeat (4) tick();
        in_flags = 8'h00;
        t_inj = tb_cnt;
        repeat (4) tick();
        send_round(12'h300);
        drain("t4_drain");
        check("t4_inject", 64'(last_data[124]), 64'd1);
        check("t4_inject_ts", last_data[191:128], t_inj + 64'd2);
        in_flags = 8'h02;
        repeat (4) tick();
        in_flags = 8'h00;
        repeat (4) tick();
        send_round(12'h310);
        drain("t4b_drain");
        check("t4b_inject_clr", 64'(last_data[124]), 64'd0);
        check("t4b_marker", 64'(last_data[125]), 64'd1);

        // navg change mid-frame is ignored until the next frame
        navg_log2 = 4'd2;
        send(0, 1);
        navg_log2 = 4'd0;
        send(1, 2); send(2, 3); send(3, 4);
        for (int r = 0; r < 3; r++) send_round(1);
        drain("t5_drain");
        check("t5_navg", 64'(last_data[47:44]), 64'd2);
        check("t5_acc0", 64'(last_data[511:480]), 64'd4);
        send_round(1);
        drain("t5b_drain");
        check("t5b_navg", 64'(last_data[47:44]), 64'd0);
        check("t5b_acc0", 64'(last_data[511:480]), 64'd1);

        // reset with three queued frames and a partial frame
        src_ready = 1'b0;
        for (int f = 0; f < 3; f++) send_round(12'h400 + f);
        send(0, 5); send(1, 6);
        repeat (3) tick();
        check("t6_level", 64'(fifo_level), 64'd3);
        pulse_reset();
        src_ready = 1'b1;
        base_frames = n_frames;
        repeat (6) tick();
        check("t6_no_spurious", 64'(n_frames - base_frames), 64'd0);
        send(0, 7); send(1, 8); send(2, 9); send(3, 10);
        drain("t6_drain");
        check("t6_seq", 64'(last_data[95:64]), 64'd0);
        check("t6_acc0", 64'(last_data[511:480]), 64'd7);

        repeat (5) tick();
        check("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
